// File: rtl/riscv_defines.sv
// Shared core encodings used by the tag policy unit: RV32 major opcodes and
// the tag ALU mode width / pass-through mode.
package riscv_defines;

  localparam int ALU_MODE_WIDTH = 2;
  localparam logic [ALU_MODE_WIDTH-1:0] ALU_MODE_OLD = 2'b00;

  localparam logic [6:0] OPCODE_OP     = 7'h33;
  localparam logic [6:0] OPCODE_OPIMM  = 7'h13;
  localparam logic [6:0] OPCODE_STORE  = 7'h23;
  localparam logic [6:0] OPCODE_LOAD   = 7'h03;
  localparam logic [6:0] OPCODE_BRANCH = 7'h63;
  localparam logic [6:0] OPCODE_JALR   = 7'h67;
  localparam logic [6:0] OPCODE_JAL    = 7'h6f;
  localparam logic [6:0] OPCODE_AUIPC  = 7'h17;
  localparam logic [6:0] OPCODE_LUI    = 7'h37;

endpackage

// File: rtl/riscv_tag_policy_pkg.sv
// Types and policy-word layout shared by the tag policy unit and its decoder.
package riscv_tag_policy_pkg;

  typedef enum logic [2:0] {
    CLASS_JUMP       = 3'd0,
    CLASS_BRANCH     = 3'd1,
    CLASS_LOADSTORE  = 3'd2,
    CLASS_INTEGER    = 3'd3,
    CLASS_SHIFT      = 3'd4,
    CLASS_COMPARISON = 3'd5,
    CLASS_LOGICAL    = 3'd6,
    CLASS_NONE       = 3'd7
  } tag_class_e;

  localparam int NUM_CLASS  = 7;
  localparam int CFG_WORD_W = 32;

  // Class c occupies bits [c*mode_w +: mode_w] of a policy word.
  function automatic int cfg_field_lsb(input int cls, input int mode_w);
    return cls * mode_w;
  endfunction

endpackage

// File: rtl/riscv_tag_classify.sv
// Combinational DIFT class decode of an RV32IM instruction word.
module riscv_tag_classify
  import riscv_defines::*;
  import riscv_tag_policy_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        pc_tag,
  output tag_class_e  tag_class,
  output logic        force_old
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    tag_class = CLASS_NONE;
    case (opcode)
      OPCODE_JAL, OPCODE_JALR:                tag_class = CLASS_JUMP;
      OPCODE_BRANCH:                          tag_class = CLASS_BRANCH;
      OPCODE_STORE, OPCODE_LUI, OPCODE_AUIPC: tag_class = CLASS_LOADSTORE;
      OPCODE_OPIMM: begin
        case (funct3)
          3'b000:                 tag_class = CLASS_INTEGER;
          3'b010, 3'b011:         tag_class = CLASS_COMPARISON;
          3'b100, 3'b110, 3'b111: tag_class = CLASS_LOGICAL;
          3'b001: if (funct7 == 7'b0000000) tag_class = CLASS_SHIFT;
          3'b101: if (funct7 == 7'b0000000 || funct7 == 7'b0100000) tag_class = CLASS_SHIFT;
          default: tag_class = CLASS_NONE;
        endcase
      end
      OPCODE_OP: begin
        // Every M-extension op shares funct7 = 0000001.
        if (funct7 == 7'b0000001) begin
          tag_class = CLASS_INTEGER;
        end else if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:                 tag_class = CLASS_INTEGER;
            3'b001, 3'b101:         tag_class = CLASS_SHIFT;
            3'b010, 3'b011:         tag_class = CLASS_COMPARISON;
            default:                tag_class = CLASS_LOGICAL;
          endcase
        end else if (funct7 == 7'b0100000) begin
          case (funct3)
            3'b000:  tag_class = CLASS_INTEGER;
            3'b101:  tag_class = CLASS_SHIFT;
            default: tag_class = CLASS_NONE;
          endcase
        end
      end
      default: tag_class = CLASS_NONE;
    endcase
  end

  assign force_old = (tag_class == CLASS_NONE) || ((tag_class == CLASS_BRANCH) && pc_tag);

endmodule

// File: rtl/riscv_tag_policy_unit.sv
// Registered multi-context DIFT tag policy lookup with a one-entry valid/ready
// output stage. Optional per-class counters: define RISCV_TAG_POLICY_STATS_EN.
module riscv_tag_policy_unit
  import riscv_defines::*;
  import riscv_tag_policy_pkg::*;
#(
  parameter int NUM_CTX = 4,
  parameter int MODE_W  = ALU_MODE_WIDTH,
  parameter int CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [31:0]           instr_rdata_i,
  input  logic                  pc_tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [MODE_W-1:0]     mode_o,
  output logic [2:0]            class_o,
  output logic [CTX_W-1:0]      ctx_o,
  input  logic                  flush_i,
  input  logic                  cfg_we_i,
  input  logic [CTX_W-1:0]      cfg_ctx_i,
  input  logic [CFG_WORD_W-1:0] cfg_wdata_i,
  input  logic                  ctx_we_i,
  input  logic [CTX_W-1:0]      ctx_i,
  input  logic                  lock_i,
`ifdef RISCV_TAG_POLICY_STATS_EN
  input  logic                  stat_clr_i,
  input  logic [2:0]            stat_sel_i,
  output logic [15:0]           stat_cnt_o,
`endif
  output logic                  cfg_err_o
);

  localparam logic [MODE_W-1:0] MODE_OLD = MODE_W'(ALU_MODE_OLD);

  logic [MODE_W-1:0] policy_tbl [NUM_CTX][NUM_CLASS];
  logic [CTX_W-1:0]  active_ctx, pend_ctx;
  logic              pend_vld, lock_r, err_r;
  tag_class_e        cls;
  logic              force_old, accept, cfg_ctx_ok, ctx_req_ok, cfg_wr;
  logic [MODE_W-1:0] mode_nxt;
  logic              unused_cfg;

  logic              vld_p1;
  logic [MODE_W-1:0] mode_p1;
  tag_class_e        class_p1;
  logic [CTX_W-1:0]  ctx_p1;

  riscv_tag_classify u_classify (
    .instr     (instr_rdata_i),
    .pc_tag    (pc_tag_i),
    .tag_class (cls),
    .force_old (force_old)
  );

  assign in_ready_o = !vld_p1 || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign cfg_ctx_ok = int'(cfg_ctx_i) < NUM_CTX;
  assign ctx_req_ok = ctx_we_i && (int'(ctx_i) < NUM_CTX);
  assign cfg_wr     = cfg_we_i && !lock_r && cfg_ctx_ok;
  assign mode_nxt   = force_old ? MODE_OLD : policy_tbl[active_ctx][cls];
  assign unused_cfg = ^cfg_wdata_i;

  // Policy table: a write lands at the edge, so a same-cycle accept sees the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CTX; c++)
        for (int k = 0; k < NUM_CLASS; k++)
          policy_tbl[c][k] <= MODE_OLD;
    end else if (cfg_wr) begin
      for (int k = 0; k < NUM_CLASS; k++)
        policy_tbl[cfg_ctx_i][k] <= cfg_wdata_i[cfg_field_lsb(k, MODE_W) +: MODE_W];
    end
  end

  // Context switch is deferred until a cycle with no accept; lock is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_ctx <= '0;
      pend_ctx   <= '0;
      pend_vld   <= 1'b0;
      lock_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      if (pend_vld && !accept) active_ctx <= pend_ctx;
      if (ctx_req_ok) begin
        pend_ctx <= ctx_i;
        pend_vld <= 1'b1;
      end else if (!accept) begin
        pend_vld <= 1'b0;
      end
      lock_r <= lock_r || lock_i;
      err_r  <= (cfg_we_i && (lock_r || !cfg_ctx_ok)) || (ctx_we_i && !ctx_req_ok);
    end
  end

  // Stage p1: result snapshot toward EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      mode_p1  <= MODE_OLD;
      class_p1 <= CLASS_NONE;
      ctx_p1   <= '0;
    end else if (flush_i) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1   <= 1'b1;
      mode_p1  <= mode_nxt;
      class_p1 <= cls;
      ctx_p1   <= active_ctx;
    end else if (out_ready_i) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid_o = vld_p1;
  assign mode_o      = mode_p1;
  assign class_o     = class_p1;
  assign ctx_o       = ctx_p1;
  assign cfg_err_o   = err_r;

`ifdef RISCV_TAG_POLICY_STATS_EN
  logic [15:0] stat_cnt [8];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) stat_cnt[k] <= '0;
    end else if (stat_clr_i) begin
      for (int k = 0; k < 8; k++) stat_cnt[k] <= '0;
    end else if (vld_p1 && out_ready_i) begin
      stat_cnt[class_p1] <= sat_inc(stat_cnt[class_p1]);
    end
  end

  assign stat_cnt_o = stat_cnt[stat_sel_i];
`endif

endmodule

// File: tb/tb_riscv_tag_policy_unit.sv
// Randomized bench for riscv_tag_policy_unit against a rule-level reference model.
module tb_riscv_tag_policy_unit;

  localparam int N_CTX = 5;
  localparam int CW    = 3;
  localparam int C_J = 0, C_B = 1, C_LS = 2, C_IN = 3, C_SH = 4, C_CM = 5, C_LG = 6, C_NO = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, pc_tag, out_valid, out_ready, flush;
  logic [31:0]   instr;
  logic [1:0]    mode;
  logic [2:0]    cls_o;
  logic [CW-1:0] ctx_o, cfg_ctx, ctx_req;
  logic          cfg_we, ctx_we, lock, cfg_err;
  logic [31:0]   cfg_wdata;
  logic          stat_clr;
  logic [2:0]    stat_sel;
  logic [15:0]   stat_cnt;

  int checks = 0;
  int failures = 0;

  // reference model state
  int m_tbl [N_CTX][7];
  int m_act, m_pend, m_mode, m_class, m_ctx, cur_cls;
  bit m_lock, m_vld, m_err;
  int m_stat [8];

  riscv_tag_policy_unit #(.NUM_CTX(N_CTX), .MODE_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_rdata_i(instr), .pc_tag_i(pc_tag), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .mode_o(mode), .class_o(cls_o), .ctx_o(ctx_o),
    .flush_i(flush), .cfg_we_i(cfg_we), .cfg_ctx_i(cfg_ctx), .cfg_wdata_i(cfg_wdata),
    .ctx_we_i(ctx_we), .ctx_i(ctx_req), .lock_i(lock),
`ifdef RISCV_TAG_POLICY_STATS_EN
    .stat_clr_i(stat_clr), .stat_sel_i(stat_sel), .stat_cnt_o(stat_cnt),
`endif
    .cfg_err_o(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
    logic [31:0] r;
    r = $urandom;
    return {f7, r[24:15], f3, r[11:7], op};
  endfunction

  // Build an instruction of a named kind; the kind determines its class.
  task automatic put_instr(input int kind);
    logic [6:0] f7r;
    logic [2:0] f3r;
    f7r = 7'($urandom);
    f3r = 3'($urandom);
    case (kind)
      0:  begin instr = mk(f7r, f3r, 7'h6f); cur_cls = C_J; end
      1:  begin instr = mk(f7r, 3'd0, 7'h67); cur_cls = C_J; end
      2:  begin instr = mk(f7r, f3r, 7'h63); cur_cls = C_B; end
      3:  begin instr = mk(f7r, f3r, 7'h23); cur_cls = C_LS; end
      4:  begin instr = mk(f7r, f3r, 7'h37); cur_cls = C_LS; end
      5:  begin instr = mk(f7r, f3r, 7'h17); cur_cls = C_LS; end
      6:  begin instr = mk(f7r, f3r, 7'h03); cur_cls = C_NO; end
      7:  begin instr = mk(f7r, 3'd0, 7'h13); cur_cls = C_IN; end
      8:  begin instr = mk(7'h00, 3'd0, 7'h33); cur_cls = C_IN; end
      9:  begin instr = mk(7'h20, 3'd0, 7'h33); cur_cls = C_IN; end
      10: begin instr = mk(7'h01, f3r, 7'h33); cur_cls = C_IN; end
      11: begin instr = mk(7'h00, 3'd1, 7'h13); cur_cls = C_SH; end
      12: begin instr = mk(7'h00, 3'd5, 7'h13); cur_cls = C_SH; end
      13: begin instr = mk(7'h20, 3'd5, 7'h13); cur_cls = C_SH; end
      14: begin instr = mk(7'h00, 3'd1, 7'h33); cur_cls = C_SH; end
      15: begin instr = mk(7'h00, 3'd5, 7'h33); cur_cls = C_SH; end
      16: begin instr = mk(7'h20, 3'd5, 7'h33); cur_cls = C_SH; end
      17: begin instr = mk(f7r, 3'd2, 7'h13); cur_cls = C_CM; end
      18: begin instr = mk(f7r, 3'd3, 7'h13); cur_cls = C_CM; end
      19: begin instr = mk(7'h00, 3'd2, 7'h33); cur_cls = C_CM; end
      20: begin instr = mk(7'h00, 3'd3, 7'h33); cur_cls = C_CM; end
      21: begin instr = mk(f7r, 3'd4, 7'h13); cur_cls = C_LG; end
      22: begin instr = mk(f7r, 3'd6, 7'h13); cur_cls = C_LG; end
      23: begin instr = mk(f7r, 3'd7, 7'h13); cur_cls = C_LG; end
      24: begin instr = mk(7'h00, 3'd4, 7'h33); cur_cls = C_LG; end
      25: begin instr = mk(7'h00, 3'd6, 7'h33); cur_cls = C_LG; end
      26: begin instr = mk(7'h00, 3'd7, 7'h33); cur_cls = C_LG; end
      27: begin instr = mk(7'h02, f3r, 7'h33); cur_cls = C_NO; end
      28: begin instr = mk(7'h20, 3'd1, 7'h13); cur_cls = C_NO; end
      29: begin instr = mk(7'h20, 3'd1, 7'h33); cur_cls = C_NO; end
      30: begin instr = mk(f7r, f3r, 7'h73); cur_cls = C_NO; end
      default: begin instr = mk(f7r, f3r, 7'h7f); cur_cls = C_NO; end
    endcase
  endtask

  task automatic m_reset();
    for (int c = 0; c < N_CTX; c++)
      for (int k = 0; k < 7; k++) m_tbl[c][k] = 0;
    for (int k = 0; k < 8; k++) m_stat[k] = 0;
    m_act = 0; m_pend = -1; m_lock = 0; m_vld = 0;
    m_mode = 0; m_class = C_NO; m_ctx = 0; m_err = 0;
  endtask

  task automatic idle();
    in_valid = 0; out_ready = 1; flush = 0; pc_tag = 0;
    cfg_we = 0; cfg_ctx = 0; cfg_wdata = 0; ctx_we = 0; ctx_req = 0; lock = 0;
    stat_clr = 0; stat_sel = 0;
  endtask

  task automatic compare_all();
    check_eq("out_valid", 32'(out_valid), 32'(m_vld));
    check_eq("in_ready", 32'(in_ready), 32'(!m_vld || out_ready));
    check_eq("mode", 32'(mode), 32'(m_mode));
    check_eq("class", 32'(cls_o), 32'(m_class));
    check_eq("ctx", 32'(ctx_o), 32'(m_ctx));
    check_eq("cfg_err", 32'(cfg_err), 32'(m_err));
`ifdef RISCV_TAG_POLICY_STATS_EN
    check_eq("stat_cnt", 32'(stat_cnt), 32'(m_stat[stat_sel]));
`endif
  endtask

  // Advance the model by one clock using the inputs now driven, then compare.
  task automatic step();
    bit acc;
    acc = in_valid && (!m_vld || out_ready);
    if (stat_clr) begin
      for (int k = 0; k < 8; k++) m_stat[k] = 0;
    end else if (m_vld && out_ready && m_stat[m_class] < 65535) begin
      m_stat[m_class]++;
    end
    if (flush) begin
      m_vld = 0;
    end else if (acc) begin
      m_vld   = 1;
      m_class = cur_cls;
      m_ctx   = m_act;
      m_mode  = (cur_cls == C_NO || (cur_cls == C_B && pc_tag)) ? 0 : m_tbl[m_act][cur_cls];
    end else if (out_ready) begin
      m_vld = 0;
    end
    m_err = (cfg_we && (m_lock || int'(cfg_ctx) >= N_CTX)) || (ctx_we && int'(ctx_req) >= N_CTX);
    if (cfg_we && !m_lock && int'(cfg_ctx) < N_CTX)
      for (int k = 0; k < 7; k++) m_tbl[cfg_ctx][k] = int'((cfg_wdata >> (2 * k)) & 32'h3);
    if (m_pend >= 0 && !acc) begin
      m_act  = m_pend;
      m_pend = -1;
    end
    if (ctx_we && int'(ctx_req) < N_CTX) m_pend = int'(ctx_req);
    if (lock) m_lock = 1;
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_vld"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_mode"}, 32'(mode), 32'd0);
    check_eq({tag, "_class"}, 32'(cls_o), 32'd7);
    check_eq({tag, "_ctx"}, 32'(ctx_o), 32'd0);
    check_eq({tag, "_err"}, 32'(cfg_err), 32'd0);
  endtask

  initial begin
    idle();
    m_reset();
    put_instr(8);
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst_n = 1;
    @(negedge clk);

    // all classes 2'b10 in ctx0, then ADD
    cfg_we = 1; cfg_ctx = 0; cfg_wdata = 32'h0000_2AAA; step();
    cfg_we = 0; in_valid = 1; put_instr(8); step();
    check_eq("add_vld", 32'(out_valid), 1); check_eq("add_mode", 32'(mode), 2);
    check_eq("add_class", 32'(cls_o), C_IN); check_eq("add_ctx", 32'(ctx_o), 0);

    // BRANCH = 2'b11; tagged PC forces OLD
    in_valid = 0; cfg_we = 1; cfg_wdata = 32'h0000_2AAE; step();
    cfg_we = 0; in_valid = 1; put_instr(2); pc_tag = 1; step();
    check_eq("br_tag_mode", 32'(mode), 0); check_eq("br_tag_class", 32'(cls_o), C_B);
    pc_tag = 0; put_instr(2); step();
    check_eq("br_mode", 32'(mode), 3);
    put_instr(6); step();
    check_eq("load_mode", 32'(mode), 0); check_eq("load_class", 32'(cls_o), C_NO);
    in_valid = 0; step();

    // stall for 3 cycles with a table write inside it
    in_valid = 1; put_instr(8); step();
    out_ready = 0; put_instr(9); cfg_we = 1; cfg_wdata = 32'h0; step();
    cfg_we = 0;
    for (int i = 0; i < 2; i++) step();
    check_eq("stall_ready", 32'(in_ready), 0); check_eq("stall_mode", 32'(mode), 2);
    out_ready = 1; step();
    check_eq("post_stall_mode", 32'(mode), 0);
    in_valid = 0; step();

    // deferred context switch
    cfg_we = 1; cfg_ctx = 0; cfg_wdata = 32'h0000_2AAA; step();
    cfg_ctx = 1; cfg_wdata = 32'h0000_0100; step();
    cfg_we = 0; in_valid = 1; put_instr(14); ctx_we = 1; ctx_req = 1; step();
    check_eq("sw1_ctx", 32'(ctx_o), 0); check_eq("sw1_mode", 32'(mode), 2);
    ctx_we = 0; in_valid = 0; step();
    in_valid = 1; put_instr(14); step();
    check_eq("sw2_ctx", 32'(ctx_o), 1); check_eq("sw2_mode", 32'(mode), 1);
    in_valid = 0; step();

    // lock with simultaneous write, then rejected write, then bad ctx
    lock = 1; cfg_we = 1; cfg_ctx = 1; cfg_wdata = 32'h0000_01C0; step();
    check_eq("lockwr_err", 32'(cfg_err), 0);
    lock = 0; cfg_wdata = 32'h0; step();
    check_eq("locked_err", 32'(cfg_err), 1);
    cfg_we = 0; step();
    check_eq("locked_err_clr", 32'(cfg_err), 0);
    in_valid = 1; put_instr(8); step();
    check_eq("locked_tbl", 32'(mode), 3);
    in_valid = 0; ctx_we = 1; ctx_req = 5; step();
    check_eq("badctx_err", 32'(cfg_err), 1);
    ctx_we = 0; step();
    in_valid = 1; put_instr(8); step();
    check_eq("badctx_ctx", 32'(ctx_o), 1);

    // flush beats a same-cycle accept, and kills a held result
    flush = 1; step();
    check_eq("flush_acc_vld", 32'(out_valid), 0);
    flush = 0; step();
    in_valid = 0; out_ready = 0; flush = 1; step();
    check_eq("flush_hold_vld", 32'(out_valid), 0);
    flush = 0; out_ready = 1;

    // async reset mid-operation discards pending ctx and table
    in_valid = 1; put_instr(8); ctx_we = 1; ctx_req = 2; step();
    idle();
    #2 rst_n = 0;
    #1 check_reset_values("async_rst");
    m_reset();
    @(negedge clk);
    rst_n = 1;
    in_valid = 1; put_instr(8); step();
    check_eq("rst_ctx", 32'(ctx_o), 0); check_eq("rst_mode", 32'(mode), 0);
    in_valid = 0; step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 16) == 0;
      pc_tag    = 1'($urandom);
      put_instr(int'($urandom % 32));
      cfg_we    = ($urandom % 8) == 0;
      cfg_ctx   = CW'($urandom);
      cfg_wdata = $urandom;
      ctx_we    = ($urandom % 10) == 0;
      ctx_req   = CW'($urandom);
      lock      = ($urandom % 500) == 0;
      stat_clr  = ($urandom % 200) == 0;
      stat_sel  = 3'($urandom);
      step();
    end

`ifdef RISCV_TAG_POLICY_STATS_EN
    idle();
    stat_clr = 1; step();
    stat_clr = 0; stat_sel = 3'(C_IN); in_valid = 1; put_instr(8);
    for (int i = 0; i < 70000; i++) step();
    in_valid = 0; step();
    check_eq("stat_sat", 32'(stat_cnt), 32'hFFFF);
    stat_clr = 1; step();
    stat_clr = 0; step();
    check_eq("stat_clr", 32'(stat_cnt), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
